// File: rtl/halfstep_seq_decoder_pkg.sv
// Shared definitions for the half-step phase sequence decoder: code table,
// FSM state type and code-to-index lookup.
package halfstep_seq_decoder_pkg;

    localparam logic [3:0] C0 = 4'b1000;
    localparam logic [3:0] C1 = 4'b1100;
    localparam logic [3:0] C2 = 4'b0100;
    localparam logic [3:0] C3 = 4'b0110;
    localparam logic [3:0] C4 = 4'b0010;
    localparam logic [3:0] C5 = 4'b0011;
    localparam logic [3:0] C6 = 4'b0001;
    localparam logic [3:0] C7 = 4'b1001;

    typedef enum logic [1:0] {
        ACQUIRE,
        TRACK,
        FAULT
    } state_t;

    // Returns {legal, idx[2:0]}; non-table codes return all zeros.
    function automatic logic [3:0] code_to_idx(input logic [3:0] code);
        case (code)
            C0:      return {1'b1, 3'd0};
            C1:      return {1'b1, 3'd1};
            C2:      return {1'b1, 3'd2};
            C3:      return {1'b1, 3'd3};
            C4:      return {1'b1, 3'd4};
            C5:      return {1'b1, 3'd5};
            C6:      return {1'b1, 3'd6};
            C7:      return {1'b1, 3'd7};
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/halfstep_seq_decoder_phase_sync.sv
// Multi-stage 4-bit flop synchronizer for the incoming phase lines;
// STAGES = 0 passes the input straight through.
module phase_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] d,
    output logic [3:0] q
);

    generate
        if (STAGES == 0) begin : g_bypass
            assign q = d;
        end else begin : g_chain
            logic [3:0] chain [STAGES];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int unsigned i = 0; i < STAGES; i++) chain[i] <= '0;
                end else begin
                    chain[0] <= d;
                    for (int unsigned i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
                end
            end

            assign q = chain[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/halfstep_seq_decoder.sv
// Receive-side half-step sequence monitor: tracks position/direction,
// pulses once per step and flags skipped steps and illegal codes.
module halfstep_seq_decoder
    import halfstep_seq_decoder_pkg::*;
#(
    parameter int unsigned POS_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [3:0]              phase_in,
    input  logic                    en,
    input  logic                    clr_err,
    output logic signed [POS_W-1:0] pos,
    output logic                    dir,
    output logic                    step_pulse,
    output logic                    locked,
    output logic                    err_skip,
    output logic                    err_illegal
);

    logic [3:0]       code_s;
    logic             legal;
    logic [2:0]       idx_new;
    logic [2:0]       diff;

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             pulse_q, pulse_d;
    logic             eskip_q, eskip_d;
    logic             eill_q, eill_d;

    phase_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (phase_in),
        .q     (code_s)
    );

    assign {legal, idx_new} = code_to_idx(code_s);
    assign diff = idx_new - idx_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACQUIRE;
            idx_q   <= '0;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            pulse_q <= 1'b0;
            eskip_q <= 1'b0;
            eill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            pulse_q <= pulse_d;
            eskip_q <= eskip_d;
            eill_q  <= eill_d;
        end
    end

    // Clear is applied first so that an error detected in the same cycle wins.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        pulse_d = 1'b0;
        eskip_d = eskip_q;
        eill_d  = eill_q;

        if (clr_err) begin
            eskip_d = 1'b0;
            eill_d  = 1'b0;
        end

        case (state_q)
            ACQUIRE: begin
                if (en && legal) begin
                    idx_d   = idx_new;
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (en) begin
                    if (!legal) begin
                        eill_d  = 1'b1;
                        state_d = FAULT;
                    end else begin
                        idx_d = idx_new;
                        case (diff)
                            3'd0: ;
                            3'd1: begin
                                pos_d   = pos_q + POS_W'(1);
                                dir_d   = 1'b0;
                                pulse_d = 1'b1;
                            end
                            3'd7: begin
                                pos_d   = pos_q - POS_W'(1);
                                dir_d   = 1'b1;
                                pulse_d = 1'b1;
                            end
                            default: eskip_d = 1'b1;
                        endcase
                    end
                end
            end
            FAULT: begin
                if (clr_err) state_d = ACQUIRE;
            end
            default: state_d = ACQUIRE;
        endcase
    end

    assign pos         = pos_q;
    assign dir         = dir_q;
    assign step_pulse  = pulse_q;
    assign locked      = (state_q == TRACK);
    assign err_skip    = eskip_q;
    assign err_illegal = eill_q;

endmodule

// File: tb/tb_halfstep_seq_decoder.sv
// Self-checking bench: directed scenarios plus random phase walks, compared
// every cycle against a behavioural model of the step decoder.
module tb_halfstep_seq_decoder;

    localparam logic [3:0] TBL [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                       4'b0010, 4'b0011, 4'b0001, 4'b1001};

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [3:0]        phase_in = '0;
    logic              en = 1'b0;
    logic              clr_err = 1'b0;
    logic signed [15:0] pos_a;
    logic signed [3:0]  pos_b;
    logic              dir_a, step_a, locked_a, eskip_a, eill_a;
    logic              dir_b, step_b, locked_b, eskip_b, eill_b;

    int n_cmp = 0;
    int n_err = 0;
    int pulses = 0;

    // model state: mode 0 = acquiring, 1 = tracking, 2 = faulted
    int       m_mode, m_idx, m_pos;
    bit       m_dir, m_pulse, m_esk, m_eil;
    logic [3:0] m_s0, m_s1;

    always #5 clk = ~clk;

    halfstep_seq_decoder #(.POS_W(16), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .phase_in(phase_in), .en(en), .clr_err(clr_err),
        .pos(pos_a), .dir(dir_a), .step_pulse(step_a), .locked(locked_a),
        .err_skip(eskip_a), .err_illegal(eill_a)
    );

    halfstep_seq_decoder #(.POS_W(4), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .phase_in(phase_in), .en(en), .clr_err(clr_err),
        .pos(pos_b), .dir(dir_b), .step_pulse(step_b), .locked(locked_b),
        .err_skip(eskip_b), .err_illegal(eill_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int find_idx(input logic [3:0] c);
        for (int i = 0; i < 8; i++) if (TBL[i] == c) return i;
        return -1;
    endfunction

    task automatic model_edge(input logic [3:0] code, input logic e, input logic c, input logic r);
        int cur;
        int ni;
        int d;
        if (!r) begin
            m_mode = 0; m_idx = 0; m_pos = 0;
            m_dir = 0; m_pulse = 0; m_esk = 0; m_eil = 0;
            m_s0 = '0; m_s1 = '0;
        end else begin
            cur = m_mode;
            ni = find_idx(m_s1);
            m_pulse = 0;
            if (c) begin
                m_esk = 0; m_eil = 0;
                if (cur == 2) m_mode = 0;
            end
            if (e && cur == 0 && ni >= 0) begin
                m_idx = ni; m_mode = 1;
            end else if (e && cur == 1) begin
                if (ni < 0) begin
                    m_eil = 1; m_mode = 2;
                end else begin
                    d = (ni - m_idx + 8) % 8;
                    if (d == 1) begin m_pos++; m_dir = 0; m_pulse = 1; end
                    else if (d == 7) begin m_pos--; m_dir = 1; m_pulse = 1; end
                    else if (d != 0) m_esk = 1;
                    m_idx = ni;
                end
            end
            m_s1 = m_s0;
            m_s0 = code;
        end
    endtask

    task automatic cyc(input logic [3:0] code, input logic e, input logic c, input logic r);
        phase_in = code; en = e; clr_err = c; rst_n = r;
        @(posedge clk);
        model_edge(code, e, c, r);
        #1;
        if (step_a) pulses++;
        check("pos16",  {16'h0, pos_a}, 32'(m_pos) & 32'hFFFF);
        check("pos4",   {28'h0, pos_b}, 32'(m_pos) & 32'hF);
        check("dir",    {30'h0, dir_a, dir_b},       {30'h0, m_dir, m_dir});
        check("pulse",  {30'h0, step_a, step_b},     {30'h0, m_pulse, m_pulse});
        check("locked", {30'h0, locked_a, locked_b}, {30'h0, m_mode == 1, m_mode == 1});
        check("eskip",  {30'h0, eskip_a, eskip_b},   {30'h0, m_esk, m_esk});
        check("eill",   {30'h0, eill_a, eill_b},     {30'h0, m_eil, m_eil});
        @(negedge clk);
    endtask

    task automatic hold(input logic [3:0] code, input logic e, input int n);
        for (int i = 0; i < n; i++) cyc(code, e, 1'b0, 1'b1);
    endtask

    task automatic reset_lock(input logic [3:0] code);
        cyc(4'b0000, 1'b1, 1'b0, 1'b0);
        cyc(4'b0000, 1'b1, 1'b0, 1'b0);
        hold(code, 1'b1, 4);
        pulses = 0;
    endtask

    initial begin
        // reset values
        cyc(4'b0000, 1'b1, 1'b0, 1'b0);
        check("rst_pos", {16'h0, pos_a}, 32'h0);
        check("rst_flags", {28'h0, dir_a, step_a, locked_a, eskip_a | eill_a}, 32'h0);

        // full forward cycle: 8 pulses, 4-bit counter wraps to -8
        reset_lock(TBL[0]);
        for (int i = 1; i <= 8; i++) hold(TBL[i % 8], 1'b1, 4);
        check("fwd_pos", {16'h0, pos_a}, 32'h0008);
        check("fwd_pos4", {28'h0, pos_b}, 32'h8);
        check("fwd_pulses", pulses, 8);
        check("fwd_state", {29'h0, locked_a, dir_a, eskip_a | eill_a}, 32'b100);

        // reverse through the 0->7 wrap
        reset_lock(TBL[0]);
        hold(TBL[7], 1'b1, 4); hold(TBL[6], 1'b1, 4); hold(TBL[5], 1'b1, 4);
        check("rev_pos", {16'h0, pos_a}, 32'hFFFD);
        check("rev_dir", {31'h0, dir_a}, 32'h1);
        check("rev_pulses", pulses, 3);

        // skipped step then a normal step
        reset_lock(TBL[2]);
        hold(TBL[5], 1'b1, 4);
        check("skip_flag", {30'h0, eskip_a, step_a}, 32'b10);
        check("skip_pos", {16'h0, pos_a}, 32'h0);
        hold(TBL[6], 1'b1, 4);
        check("skip_next_pos", {16'h0, pos_a}, 32'h1);
        check("skip_sticky", {31'h0, eskip_a}, 32'h1);
        cyc(TBL[6], 1'b1, 1'b1, 1'b1);
        check("skip_clr", {31'h0, eskip_a}, 32'h0);

        // illegal code, fault, clear and reacquire
        reset_lock(TBL[0]);
        hold(4'b1111, 1'b1, 4);
        check("ill_flag", {30'h0, eill_a, locked_a}, 32'b10);
        hold(TBL[1], 1'b1, 4);
        check("fault_ignores", {30'h0, locked_a, step_a}, 32'b00);
        cyc(TBL[1], 1'b1, 1'b1, 1'b1);
        check("ill_clr", {30'h0, eill_a, eskip_a}, 32'b00);
        hold(TBL[1], 1'b1, 2);
        check("reacq", {31'h0, locked_a}, 32'h1);
        check("reacq_pos", {16'h0, pos_a}, 32'h0);

        // enable gated: steps while disabled become one skip
        reset_lock(TBL[0]);
        hold(TBL[1], 1'b0, 4); hold(TBL[2], 1'b0, 4); hold(TBL[3], 1'b0, 4);
        check("en0_pulses", pulses, 0);
        hold(TBL[3], 1'b1, 2);
        check("en1_skip", {31'h0, eskip_a}, 32'h1);
        hold(TBL[4], 1'b1, 4);
        cyc(TBL[4], 1'b1, 1'b0, 1'b0);
        check("midrst", {16'h0, pos_a}, 32'h0);
        check("midrst_flags", {28'h0, dir_a, locked_a, eskip_a, eill_a}, 32'h0);

        // randomized walk
        begin
            int ci;
            logic [3:0] code;
            ci = 0;
            code = TBL[0];
            for (int n = 0; n < 4000; n++) begin
                int r;
                r = $urandom_range(99);
                if (r < 12) begin ci = (ci + 1) % 8; code = TBL[ci]; end
                else if (r < 22) begin ci = (ci + 7) % 8; code = TBL[ci]; end
                else if (r < 25) begin ci = $urandom_range(7); code = TBL[ci]; end
                else if (r < 27) code = 4'($urandom);
                else if (r < 35) code = TBL[ci];
                cyc(code, ($urandom_range(9) != 0), ($urandom_range(39) == 0),
                    ($urandom_range(199) != 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
